pla_sweep_ctrl: RTL and testbench

PLA_SWEEP_CTRL -- requirements
Module: pla_sweep_ctrl

---
 rtl/pla_sweep_ctrl_if.sv | 29 ++
 rtl/pla_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_pla_sweep_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pla_sweep_ctrl_if.sv
// Bus bundle for the PLA sweep controller: sweep request/range,
// function drive/response, and status/result outputs.
interface pla_sweep_ctrl_if #(
  parameter int XW = 14
);
  logic          start;
  logic          abort;
  logic [XW-1:0] lo;
  logic [XW-1:0] hi;
  logic [XW-1:0] x_out;
  logic          y_in;
  logic          busy;
  logic          done;
  logic [XW:0]   onset_cnt;
  logic [XW-1:0] first_on;
  logic          first_valid;
  logic          err;
  logic          aborted;

  modport slave (
    input  start, abort, lo, hi, y_in,
    output x_out, busy, done, onset_cnt, first_on, first_valid, err, aborted
  );

  modport master (
    output start, abort, lo, hi, y_in,
    input  x_out, busy, done, onset_cnt, first_on, first_valid, err, aborted
  );
endinterface

// File: rtl/pla_sweep_ctrl.sv
// Sweeps a combinational function's input vector from lo to hi, waiting
// SETTLE cycles per vector before sampling y_in, and reports the onset
// count and the lowest vector that produced a 1.
//
// state  | meaning
// IDLE   | waiting for start; results held
// WAIT   | vector driven, settle down-counter running
// SAMPLE | y_in sampled for current vector; advance or finish
// DONE   | one-cycle completion pulse, then IDLE
module pla_sweep_ctrl #(
  parameter int XW     = 14,
  parameter int SETTLE = 1
) (
  input logic             clk,
  input logic             rst,
  pla_sweep_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  logic [1:0]    state;
  logic [3:0]    settle_cnt;
  logic [XW-1:0] x_q;
  logic [XW-1:0] hi_q;
  logic [XW-1:0] first_q;
  logic [XW:0]   onset_q;
  logic          fv_q;
  logic          err_q;
  logic          ab_q;

  // Sweep sequencer: range capture, settle timing, sampling and result update.
  // The end-of-sweep test uses the captured hi so hi = all-ones stops
  // before x_q would wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      x_q        <= '0;
      hi_q       <= '0;
      first_q    <= '0;
      onset_q    <= '0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      ab_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            onset_q <= '0;
            fv_q    <= 1'b0;
            ab_q    <= 1'b0;
            if (bus.lo <= bus.hi) begin
              x_q        <= bus.lo;
              hi_q       <= bus.hi;
              err_q      <= 1'b0;
              settle_cnt <= SETTLE_LD;
              state      <= S_WAIT;
            end else begin
              err_q <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            ab_q  <= 1'b1;
            state <= S_DONE;
          end else if (settle_cnt == 4'd1) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (bus.abort) begin
            ab_q  <= 1'b1;
            state <= S_DONE;
          end else begin
            if (bus.y_in) begin
              onset_q <= onset_q + (XW+1)'(1);
              if (!fv_q) begin
                first_q <= x_q;
                fv_q    <= 1'b1;
              end
            end
            if (x_q == hi_q) begin
              state <= S_DONE;
            end else begin
              x_q        <= x_q + XW'(1);
              settle_cnt <= SETTLE_LD;
              state      <= S_WAIT;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output drive: status decoded straight from the state register so reset
  // clears it without waiting for a clock.
  always_comb begin
    bus.x_out       = x_q;
    bus.busy        = (state != S_IDLE);
    bus.done        = (state == S_DONE);
    bus.onset_cnt   = onset_q;
    bus.first_on    = first_q;
    bus.first_valid = fv_q;
    bus.err         = err_q;
    bus.aborted     = ab_q;
  end

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Scoreboard bench for pla_sweep_ctrl: stimulus pushes hand-computed
// expected results, a monitor pops and compares on every done pulse.
module tb_pla_sweep_ctrl;
  localparam int XW = 14;

  typedef struct {
    int onset;
    int fo;
    bit fv;
    bit err;
    bit ab;
    int lat;
    int xf;
  } exp_t;

  logic clk;
  logic rst;
  bit   ymode;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  pla_sweep_ctrl_if #(.XW(XW)) vif ();

  pla_sweep_ctrl #(.XW(XW), .SETTLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running cycle count for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // function under test: either y0 = (x == 5) or y0 = 1
  always @* vif.y_in = ymode ? 1'b1 : (vif.x_out == XW'(5));

  function automatic void chk(string name, longint act, longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // monitor: measure start-to-done latency and compare results at done
  initial begin
    bit   bp;
    int   t0;
    exp_t e;
    bp = 1'b0;
    t0 = 0;
    forever begin
      @(negedge clk);
      if (vif.busy && !bp) t0 = cyc;
      bp = vif.busy;
      if (vif.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("onset_cnt", vif.onset_cnt, e.onset);
          chk("first_valid", vif.first_valid, e.fv);
          if (e.fv) chk("first_on", vif.first_on, e.fo);
          chk("err", vif.err, e.err);
          chk("aborted", vif.aborted, e.ab);
          chk("latency", cyc - t0, e.lat);
          chk("x_out_final", vif.x_out, e.xf);
        end
      end
    end
  end

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout_done", 0, 1);
      sb.delete();
    end
  endtask

  task automatic pulse_start(input int lo, input int hi);
    @(negedge clk);
    vif.lo    = XW'(lo);
    vif.hi    = XW'(hi);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    // range changes after acceptance must not affect the sweep
    vif.lo = XW'(lo + 1);
    vif.hi = '0;
  endtask

  task automatic do_sweep(input int lo, input int hi, input bit ym, input exp_t e, input int budget);
    ymode = ym;
    sb.push_back(e);
    pulse_start(lo, hi);
    wait_empty(budget);
  endtask

  task automatic wait_x(input int v, input int budget);
    for (int i = 0; i < budget && vif.x_out != XW'(v); i++) @(negedge clk);
    if (vif.x_out != XW'(v)) chk("timeout_x_out", vif.x_out, v);
  endtask

  initial begin
    exp_t e;
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    ymode = 1'b0;
    rst = 1'b1;
    vif.start = 1'b0;
    vif.abort = 1'b0;
    vif.lo = '0;
    vif.hi = '0;

    // reset state
    #3;
    chk("rst_busy", vif.busy, 0);
    chk("rst_done", vif.done, 0);
    chk("rst_x_out", vif.x_out, 0);
    chk("rst_onset", vif.onset_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // y = (x==5), 0..9: 10 vectors, 20 cycles
    e = '{onset: 1, fo: 5, fv: 1, err: 0, ab: 0, lat: 20, xf: 9};
    do_sweep(0, 9, 1'b0, e, 100);

    // results held in IDLE
    repeat (5) @(negedge clk);
    chk("hold_onset", vif.onset_cnt, 1);
    chk("hold_first_on", vif.first_on, 5);
    chk("hold_x_out", vif.x_out, 9);
    chk("hold_busy", vif.busy, 0);

    // rejected range: done next cycle, x_out untouched
    e = '{onset: 0, fo: 0, fv: 0, err: 1, ab: 0, lat: 0, xf: 9};
    do_sweep(10, 3, 1'b0, e, 20);

    // single-vector sweep lo == hi
    e = '{onset: 0, fo: 0, fv: 0, err: 0, ab: 0, lat: 2, xf: 7};
    do_sweep(7, 7, 1'b0, e, 20);

    // abort ignored in IDLE
    @(negedge clk);
    vif.abort = 1'b1;
    repeat (3) @(negedge clk);
    vif.abort = 1'b0;
    chk("idle_abort_busy", vif.busy, 0);
    chk("idle_abort_flag", vif.aborted, 0);

    // abort in SAMPLE of x=4 with y=1: x=0..3 counted, sample of 4 discarded
    ymode = 1'b1;
    e = '{onset: 4, fo: 0, fv: 1, err: 0, ab: 1, lat: 10, xf: 4};
    sb.push_back(e);
    pulse_start(0, 100);
    wait_x(4, 50);
    @(negedge clk);
    vif.abort = 1'b1;
    @(negedge clk);
    vif.abort = 1'b0;
    wait_empty(20);

    // reset mid-sweep at x=7: outputs clear at once, no done
    ymode = 1'b0;
    pulse_start(0, 9);
    wait_x(7, 50);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_x_out", vif.x_out, 0);
    chk("mid_rst_onset", vif.onset_cnt, 0);
    chk("mid_rst_first_on", vif.first_on, 0);
    chk("mid_rst_first_valid", vif.first_valid, 0);
    chk("mid_rst_busy", vif.busy, 0);
    chk("mid_rst_done", vif.done, 0);
    chk("mid_rst_err", vif.err, 0);
    chk("mid_rst_aborted", vif.aborted, 0);
    @(negedge clk);
    rst = 1'b0;
    e = '{onset: 1, fo: 5, fv: 1, err: 0, ab: 0, lat: 20, xf: 9};
    do_sweep(0, 9, 1'b0, e, 100);

    // start held high: one sweep per IDLE visit
    ymode = 1'b1;
    e = '{onset: 3, fo: 2, fv: 1, err: 0, ab: 0, lat: 6, xf: 4};
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    vif.lo = XW'(2);
    vif.hi = XW'(4);
    vif.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40 && !vif.done; i++) @(negedge clk);
    chk("held_first_done", vif.done, 1);
    @(negedge clk);
    chk("held_idle_gap_busy", vif.busy, 0);
    @(negedge clk);
    chk("held_restart_busy", vif.busy, 1);
    vif.start = 1'b0;
    wait_empty(40);

    // full sweep with y=1: 16384 onsets, no wrap
    e = '{onset: 16384, fo: 0, fv: 1, err: 0, ab: 0, lat: 32768, xf: 16383};
    do_sweep(0, 16383, 1'b1, e, 33000);
    repeat (3) @(negedge clk);
    chk("full_no_restart", vif.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
